dma_wr: RTL and testbench

Write-direction DMA engine: the counterpart of the read DMA.
- Accepts a write request (start byte address plus length in 128-bit words) and a valid/ready stream of 128-bit data words.
- Fills the MCB port-0 write FIFO and issues MCB write commands in bursts of at most MAX_BL words.
- Sits between the accelerator result path and the memctrl user port.
- The MCB cmd_clk and wr_clk are tied to clk at the top level.

---
 rtl/dma_pkg.sv | 18 +
 rtl/dma_wr.sv | 156 +++++++++++++++
 tb/tb_dma_wr.sv | 335 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dma_pkg.sv
// Shared definitions for the DMA engines: MCB instruction codes, word geometry
// and the write-engine state encoding.
package dma_pkg;

  localparam logic [2:0] MCB_INSTR_WR   = 3'b000;
  localparam logic [2:0] MCB_INSTR_RD   = 3'b001;

  localparam int         BYTES_PER_WORD = 16;
  localparam int         MAX_BL         = 64;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FILL,
    ST_CMD,
    ST_DONE
  } dma_wr_state_e;

endpackage

// File: rtl/dma_wr.sv
// Write-direction DMA engine: streams 128-bit words into the MCB port-0 write
// FIFO and issues one write command per burst once that burst is fully queued.
module dma_wr #(
  parameter int DATA_W = 128,
  parameter int MASK_W = 16,
  parameter int ADDR_W = 30,
  parameter int LEN_W  = 16,
  parameter int MAX_BL = dma_pkg::MAX_BL
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              calib_done,

  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [LEN_W-1:0]  req_len,

  input  logic              dma_valid,
  output logic              dma_ready,
  input  logic [DATA_W-1:0] data,

  output logic              busy,
  output logic              done,
  output logic              error,

  output logic              mcb_cmd_en,
  output logic [2:0]        mcb_cmd_instr,
  output logic [5:0]        mcb_cmd_bl,
  output logic [ADDR_W-1:0] mcb_cmd_byte_addr,
  input  logic              mcb_cmd_full,

  output logic              mcb_wr_en,
  output logic [MASK_W-1:0] mcb_wr_mask,
  output logic [DATA_W-1:0] mcb_wr_data,
  input  logic              mcb_wr_full,
  input  logic              mcb_wr_underrun,
  input  logic              mcb_wr_error
);

  import dma_pkg::*;

  // Wide enough to hold a full burst count (0..MAX_BL).
  localparam int BURST_W = $clog2(MAX_BL + 1);

  dma_wr_state_e      state_q, state_d;
  logic [ADDR_W-1:0]  addr_q;
  logic [LEN_W-1:0]   rem_q;
  logic [BURST_W-1:0] burst_q;
  logic [BURST_W-1:0] wc_q;
  logic               error_q;

  logic               accept;
  logic               push;
  logic               issue;
  logic [LEN_W-1:0]   rem_after;
  logic [BURST_W-1:0] burst_m1;

  function automatic logic [BURST_W-1:0] clip_burst(input logic [LEN_W-1:0] words);
    if (words > LEN_W'(MAX_BL)) return BURST_W'(MAX_BL);
    return words[BURST_W-1:0];
  endfunction

  assign rem_after = rem_q - LEN_W'(burst_q);
  assign burst_m1  = burst_q - BURST_W'(1);

  // NOTE: every output of this block gets a default before the case so no path
  // leaves a variable unassigned; otherwise synthesis would infer latches.
  always_comb begin
    state_d    = state_q;
    req_ready  = 1'b0;
    dma_ready  = 1'b0;
    mcb_cmd_en = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // Held low during reset so nothing can be handed over on that edge.
        req_ready = calib_done & ~rst;
        if (req_valid && req_ready) begin
          state_d = (req_len == '0) ? ST_DONE : ST_FILL;
        end
      end
      ST_FILL: begin
        busy      = 1'b1;
        dma_ready = ~mcb_wr_full;
        if (dma_valid && dma_ready && wc_q == burst_m1) begin
          state_d = ST_CMD;
        end
      end
      ST_CMD: begin
        busy       = 1'b1;
        mcb_cmd_en = ~mcb_cmd_full;
        if (mcb_cmd_en) begin
          state_d = (rem_after == '0) ? ST_DONE : ST_FILL;
        end
      end
      ST_DONE: begin
        busy    = 1'b1;
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign accept = req_valid & req_ready;
  assign push   = dma_valid & dma_ready;
  assign issue  = mcb_cmd_en;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order within the block.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      rem_q   <= '0;
      burst_q <= '0;
      wc_q    <= '0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;

      if (accept) begin
        addr_q  <= req_addr & ~ADDR_W'(BYTES_PER_WORD - 1);
        rem_q   <= req_len;
        burst_q <= clip_burst(req_len);
        wc_q    <= '0;
        error_q <= 1'b0;
      end else if (busy && (mcb_wr_underrun || mcb_wr_error)) begin
        error_q <= 1'b1;
      end

      if (push) begin
        wc_q <= wc_q + BURST_W'(1);
      end

      // The next burst size is fixed here, on the way back into FILL.
      if (issue) begin
        addr_q  <= addr_q + ADDR_W'(burst_q) * ADDR_W'(BYTES_PER_WORD);
        rem_q   <= rem_after;
        burst_q <= clip_burst(rem_after);
        wc_q    <= '0;
      end
    end
  end

  assign error             = error_q;
  assign mcb_wr_en         = push;
  assign mcb_wr_data       = data;
  assign mcb_wr_mask       = '0;
  assign mcb_cmd_instr     = MCB_INSTR_WR;
  assign mcb_cmd_bl        = 6'(burst_m1);
  assign mcb_cmd_byte_addr = addr_q;

endmodule

// File: tb/tb_dma_wr.sv
// Self-checking bench for dma_wr: directed vectors, hand-written corner cases
// and randomized requests compared with a burst-splitting reference model.
module tb_dma_wr;

  logic          clk = 1'b0;
  logic          rst;
  logic          calib_done;
  logic          req_valid;
  logic          req_ready;
  logic [29:0]   req_addr;
  logic [15:0]   req_len;
  logic          dma_valid;
  logic          dma_ready;
  logic [127:0]  data;
  logic          busy;
  logic          done;
  logic          error;
  logic          mcb_cmd_en;
  logic [2:0]    mcb_cmd_instr;
  logic [5:0]    mcb_cmd_bl;
  logic [29:0]   mcb_cmd_byte_addr;
  logic          mcb_cmd_full;
  logic          mcb_wr_en;
  logic [15:0]   mcb_wr_mask;
  logic [127:0]  mcb_wr_data;
  logic          mcb_wr_full;
  logic          mcb_wr_underrun;
  logic          mcb_wr_error;

  always #5 clk = ~clk;

  dma_wr dut (
    .clk               (clk),
    .rst               (rst),
    .calib_done        (calib_done),
    .req_valid         (req_valid),
    .req_ready         (req_ready),
    .req_addr          (req_addr),
    .req_len           (req_len),
    .dma_valid         (dma_valid),
    .dma_ready         (dma_ready),
    .data              (data),
    .busy              (busy),
    .done              (done),
    .error             (error),
    .mcb_cmd_en        (mcb_cmd_en),
    .mcb_cmd_instr     (mcb_cmd_instr),
    .mcb_cmd_bl        (mcb_cmd_bl),
    .mcb_cmd_byte_addr (mcb_cmd_byte_addr),
    .mcb_cmd_full      (mcb_cmd_full),
    .mcb_wr_en         (mcb_wr_en),
    .mcb_wr_mask       (mcb_wr_mask),
    .mcb_wr_data       (mcb_wr_data),
    .mcb_wr_full       (mcb_wr_full),
    .mcb_wr_underrun   (mcb_wr_underrun),
    .mcb_wr_error      (mcb_wr_error)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // MCB-side observer: records every pushed word and issued command, and
  // counts protocol violations (push while full, command before its words
  // are queued, data path or constant fields wrong).
  logic [127:0] wr_q[$];
  logic [35:0]  cmd_q[$];
  int           viol      = 0;
  int           done_cnt  = 0;
  int           since_cmd = 0;

  always @(negedge clk) begin
    int v;
    int sc;
    v  = 0;
    sc = since_cmd;
    if (rst) begin
      sc = 0;
    end else begin
      if (mcb_wr_en) begin
        wr_q.push_back(mcb_wr_data);
        sc++;
        if (mcb_wr_full) v++;
        if (mcb_wr_data !== data) v++;
      end
      if (mcb_wr_en !== (dma_valid & dma_ready)) v++;
      if (mcb_cmd_en) begin
        cmd_q.push_back({mcb_cmd_bl, mcb_cmd_byte_addr});
        if (mcb_cmd_full || dma_ready || mcb_wr_en) v++;
        if (sc != int'(mcb_cmd_bl) + 1) v++;
        if (mcb_cmd_instr !== 3'b000) v++;
        sc = 0;
      end
      if (mcb_wr_mask !== 16'h0) v++;
      if (done) done_cnt <= done_cnt + 1;
    end
    since_cmd <= sc;
    viol      <= viol + v;
  end

  // Results of the most recent run_req, used by the directed checks.
  int          last_ncmd;
  logic [35:0] first_cmd;
  logic [35:0] last_cmd;
  logic        err_at_done;
  logic        err_after_accept;

  // Drives one complete request and compares the MCB traffic with a model
  // that splits the request into MAX_BL-word bursts by plain arithmetic.
  task automatic run_req(input logic [29:0] addr, input int len, input bit stall,
                         input int valid_pct, input int err_cycle, input bit use_underrun);
    logic [127:0] words[$];
    logic [35:0]  exp_cmds[$];
    logic [29:0]  a;
    int           r, b, idx, mism, cmd_base, wr_base, viol_base, done_base;
    bit           accepted, finished;

    for (int i = 0; i < len; i++) words.push_back({$urandom, $urandom, $urandom, $urandom});
    a = addr & ~30'hF;
    r = len;
    while (r > 0) begin
      b = (r > 64) ? 64 : r;
      exp_cmds.push_back({6'(b - 1), a});
      a = a + 30'(b * 16);
      r = r - b;
    end

    cmd_base  = cmd_q.size();
    wr_base   = wr_q.size();
    viol_base = viol;
    done_base = done_cnt;
    err_at_done      = 1'bx;
    err_after_accept = 1'bx;

    req_addr  = addr;
    req_len   = 16'(len);
    req_valid = 1'b1;
    accepted  = 1'b0;
    for (int c = 0; c < 50 && !accepted; c++) begin
      @(negedge clk);
      if (req_ready) accepted = 1'b1;
      @(posedge clk); #1;
    end
    req_valid = 1'b0;
    check("req_accept", accepted, 1'b1);

    idx      = 0;
    finished = 1'b0;
    for (int c = 0; c < 20000 && !finished; c++) begin
      dma_valid       = (idx < len) && ($urandom_range(99) < valid_pct);
      data            = dma_valid ? words[idx] : {$urandom, $urandom, $urandom, $urandom};
      mcb_wr_full     = stall && ($urandom_range(3) == 0);
      mcb_cmd_full    = stall && ($urandom_range(2) == 0);
      mcb_wr_error    = (c == err_cycle) && !use_underrun;
      mcb_wr_underrun = (c == err_cycle) && use_underrun;
      @(negedge clk);
      if (c == 0) err_after_accept = error;
      if (dma_valid && dma_ready) idx++;
      if (done) begin
        finished    = 1'b1;
        err_at_done = error;
      end
      @(posedge clk); #1;
    end
    dma_valid       = 1'b0;
    mcb_wr_full     = 1'b0;
    mcb_cmd_full    = 1'b0;
    mcb_wr_error    = 1'b0;
    mcb_wr_underrun = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("req_finish", finished, 1'b1);

    last_ncmd = cmd_q.size() - cmd_base;
    first_cmd = (last_ncmd > 0) ? cmd_q[cmd_base] : '1;
    last_cmd  = (last_ncmd > 0) ? cmd_q[cmd_q.size() - 1] : '1;
    check("cmd_count", 64'(last_ncmd), 64'(exp_cmds.size()));
    for (int i = 0; i < exp_cmds.size() && i < last_ncmd; i++) begin
      check($sformatf("cmd%0d_bl_addr", i), 64'(cmd_q[cmd_base + i]), 64'(exp_cmds[i]));
    end

    mism = 0;
    for (int i = 0; i < len; i++) begin
      if (wr_base + i >= wr_q.size()) mism++;
      else if (wr_q[wr_base + i] !== words[i]) mism++;
    end
    check("word_count", 64'(wr_q.size() - wr_base), 64'(len));
    check("word_data", 64'(mism), 64'd0);
    check("protocol", 64'(viol - viol_base), 64'd0);
    check("done_pulses", 64'(done_cnt - done_base), 64'd1);
  endtask

  typedef struct {
    logic [29:0] addr;
    int          len;
    bit          stall;
    int          ncmd;
    logic [5:0]  bl0;
    logic [29:0] a0;
    logic [5:0]  bln;
    logic [29:0] an;
  } vec_t;

  vec_t vecs[7];

  initial begin
    #800000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
    $fatal(1, "timeout");
  end

  initial begin
    logic any;

    vecs[0] = '{30'h100,        4,   1'b0, 1, 6'd3,  30'h100,        6'd3,  30'h100};
    vecs[1] = '{30'h1000,       130, 1'b0, 3, 6'd63, 30'h1000,       6'd1,  30'h1800};
    vecs[2] = '{30'h10F,        1,   1'b0, 1, 6'd0,  30'h100,        6'd0,  30'h100};
    vecs[3] = '{30'h2000,       64,  1'b0, 1, 6'd63, 30'h2000,       6'd63, 30'h2000};
    vecs[4] = '{30'h3000,       65,  1'b0, 2, 6'd63, 30'h3000,       6'd0,  30'h3400};
    vecs[5] = '{30'h4000,       70,  1'b1, 2, 6'd63, 30'h4000,       6'd5,  30'h4400};
    vecs[6] = '{30'h3FFF_FC00,  65,  1'b1, 2, 6'd63, 30'h3FFF_FC00,  6'd0,  30'h0};

    rst             = 1'b1;
    calib_done      = 1'b0;
    req_valid       = 1'b0;
    req_addr        = '0;
    req_len         = '0;
    dma_valid       = 1'b0;
    data            = '0;
    mcb_cmd_full    = 1'b0;
    mcb_wr_full     = 1'b0;
    mcb_wr_underrun = 1'b0;
    mcb_wr_error    = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    check("reset_outputs", {req_ready, dma_ready, busy, done, error, mcb_cmd_en, mcb_wr_en}, 7'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Requests are held off until calibration completes.
    req_valid = 1'b1;
    req_len   = 16'd0;
    req_addr  = 30'h500;
    any       = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      any = any | req_ready | busy | mcb_cmd_en | mcb_wr_en;
      @(posedge clk); #1;
    end
    check("calib_gate", any, 1'b0);
    calib_done = 1'b1;
    @(negedge clk);
    check("calib_req_ready", req_ready, 1'b1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(negedge clk);
    check("len0_busy_done", {busy, done}, 2'b11);
    @(posedge clk); #1;
    @(negedge clk);
    check("len0_back_idle", {busy, done, req_ready}, 3'b001);
    check("len0_no_mcb", 64'(cmd_q.size() + wr_q.size()), 64'd0);
    @(posedge clk); #1;

    for (int i = 0; i < 7; i++) begin
      run_req(vecs[i].addr, vecs[i].len, vecs[i].stall, vecs[i].stall ? 70 : 100, -1, 1'b0);
      check($sformatf("vec%0d_ncmd", i), 64'(last_ncmd), 64'(vecs[i].ncmd));
      check($sformatf("vec%0d_first", i), 64'(first_cmd), 64'({vecs[i].bl0, vecs[i].a0}));
      check($sformatf("vec%0d_last", i), 64'(last_cmd), 64'({vecs[i].bln, vecs[i].an}));
    end

    // Sticky error: set mid-request, still set at done and afterwards,
    // cleared by the next accepted request; flags while idle are ignored.
    run_req(30'h9000, 20, 1'b0, 100, 3, 1'b0);
    check("err_at_done", err_at_done, 1'b1);
    @(negedge clk);
    check("err_sticky_idle", error, 1'b1);
    @(posedge clk); #1;
    run_req(30'hA000, 3, 1'b0, 100, -1, 1'b0);
    check("err_cleared_on_accept", err_after_accept, 1'b0);
    run_req(30'hB000, 10, 1'b1, 80, 2, 1'b1);
    check("underrun_at_done", err_at_done, 1'b1);
    run_req(30'hC000, 2, 1'b0, 100, -1, 1'b0);
    mcb_wr_error = 1'b1;
    @(posedge clk); #1;
    mcb_wr_error = 1'b0;
    @(negedge clk);
    check("err_ignored_idle", error, 1'b0);
    @(posedge clk); #1;

    // Reset in the middle of FILL, with error already set.
    req_addr  = 30'h800;
    req_len   = 16'd10;
    req_valid = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
    req_valid    = 1'b0;
    dma_valid    = 1'b1;
    mcb_wr_error = 1'b1;
    for (int c = 0; c < 3; c++) begin
      data = {$urandom, $urandom, $urandom, $urandom};
      @(posedge clk); #1;
      mcb_wr_error = 1'b0;
    end
    @(negedge clk);
    check("pre_rst_busy_err", {busy, error}, 2'b11);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    check("rst_mid_fill", {req_ready, dma_ready, busy, done, error, mcb_cmd_en, mcb_wr_en}, 7'd0);
    dma_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst_release_idle", {req_ready, busy}, 2'b10);
    @(posedge clk); #1;

    for (int i = 0; i < 8; i++) begin
      run_req(30'($urandom), $urandom_range(200, 1), 1'($urandom_range(1)),
              $urandom_range(100, 50), -1, 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
